sw_debounce_sync: RTL and testbench

Upstream input-conditioning stage for the counter/toggle LED core. It takes raw board slide switches and produces glitch-free levels that drive the core's sw input. Per channel it provides:
- a synchroniser;
- a counter-based debounce state machine;
- single-cycle edge pulses;
- a sticky change flag that the processor reads through an AXI register.

---
 rtl/sw_debounce_pkg.sv | 14 +
 rtl/sw_debounce_ch.sv | 98 +++++++++
 rtl/sw_debounce_sync.sv | 63 ++++++
 tb/tb_sw_debounce_sync.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
// Shared types and defaults for the switch synchroniser/debouncer.
package sw_debounce_pkg;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } deb_state_e;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int unsigned SYNC_STAGES_DEF     = 2;
    // Smallest counter width whose range exceeds the default debounce count
    localparam int unsigned CNT_W_MIN_DEF       = $clog2(DEBOUNCE_CYCLES_DEF + 1);

endpackage

// File: rtl/sw_debounce_ch.sv
// One switch channel: synchroniser chain, qualification counter/FSM and edge pulses.
module sw_debounce_ch
    import sw_debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_MIN_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sw_async,
    input  logic en,
    input  logic restart,
    output logic sw,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    deb_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   sw_d, rise_d, fall_d;

    assign s = sync_q[SYNC_STAGES-1];

    // Synchroniser chain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw_async};
        end
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            sw      <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sw      <= sw_d;
            rise    <= rise_d;
            fall    <= fall_d;
        end
    end

    // Next state: bypass or an enable change abandons any qualification in progress
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!en || restart) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_STABLE: begin
                    if (s != sw) begin
                        state_d = ST_COUNTING;
                        cnt_d   = CNT_W'(1);
                    end
                end
                ST_COUNTING: begin
                    if ((s == sw) || (cnt_q == CNT_MAX)) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output next values: accept on a full count, or follow s directly in bypass
    always_comb begin
        sw_d = sw;
        if (!en) begin
            sw_d = s;
        end else if (!restart && (state_q == ST_COUNTING) && (s != sw) && (cnt_q == CNT_MAX)) begin
            sw_d = s;
        end
        rise_d = sw_d & ~sw;
        fall_d = ~sw_d & sw;
    end

endmodule

// File: rtl/sw_debounce_sync.sv
// Slide-switch conditioning: per-channel debouncers plus sticky change flags.
module sw_debounce_sync
    import sw_debounce_pkg::*;
#(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_MIN_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] i_sw,
    input  logic              i_debounce_en,
    input  logic              i_clr_changed,
    output logic [NUM_CH-1:0] o_sw,
    output logic [NUM_CH-1:0] o_rise,
    output logic [NUM_CH-1:0] o_fall,
    output logic [NUM_CH-1:0] o_changed
);

    logic              en_q;
    logic              en_chg;
    logic [NUM_CH-1:0] changed_d;

    assign en_chg = en_q ^ i_debounce_en;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        sw_debounce_ch #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .sw_async (i_sw[g]),
            .en       (i_debounce_en),
            .restart  (en_chg),
            .sw       (o_sw[g]),
            .rise     (o_rise[g]),
            .fall     (o_fall[g])
        );
    end

    // A new edge beats a simultaneous clear
    always_comb begin
        changed_d = o_changed;
        if (i_clr_changed) begin
            changed_d = '0;
        end
        changed_d = changed_d | o_rise | o_fall;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q      <= 1'b1;
            o_changed <= '0;
        end else begin
            en_q      <= i_debounce_en;
            o_changed <= changed_d;
        end
    end

endmodule

// File: tb/tb_sw_debounce_sync.sv
// Directed bench for sw_debounce_sync with a queue-based edge-event scoreboard.
module tb_sw_debounce_sync;

    logic       clk;
    logic       reset_n;
    logic [3:0] i_sw;
    logic       i_debounce_en;
    logic       i_clr_changed;
    logic [3:0] o_sw;
    logic [3:0] o_rise;
    logic [3:0] o_fall;
    logic [3:0] o_changed;

    typedef struct {
        int         cyc;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] sw;
    } exp_t;

    exp_t exp_q[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n;

    sw_debounce_sync #(
        .NUM_CH          (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (8),
        .CNT_W           (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_sw          (i_sw),
        .i_debounce_en (i_debounce_en),
        .i_clr_changed (i_clr_changed),
        .o_sw          (o_sw),
        .o_rise        (o_rise),
        .o_fall        (o_fall),
        .o_changed     (o_changed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int c, input logic [3:0] r, input logic [3:0] f, input logic [3:0] s);
        exp_t e;
        e.cyc  = c;
        e.rise = r;
        e.fall = f;
        e.sw   = s;
        exp_q.push_back(e);
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic clr_pulse();
        i_clr_changed = 1'b1;
        step(1);
        i_clr_changed = 1'b0;
    endtask

    // Monitor: every edge pulse the DUT presents is matched against the next expected event
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && ((o_rise | o_fall) != 4'h0)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: rise %h fall %h at edge %0d, none expected",
                         o_rise, o_fall, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("event_edge", cyc, e.cyc);
                chk("event_rise", int'(o_rise), int'(e.rise));
                chk("event_fall", int'(o_fall), int'(e.fall));
                chk("event_sw",   int'(o_sw),   int'(e.sw));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n       = 1'b0;
        i_sw          = 4'hF;
        i_debounce_en = 1'b1;
        i_clr_changed = 1'b0;
        step(3);

        // Reset held: everything low
        chk("reset_sw",      int'(o_sw),      0);
        chk("reset_rise",    int'(o_rise),    0);
        chk("reset_changed", int'(o_changed), 0);

        // Switches high through reset release rise after the full latency
        reset_n = 1'b1;
        n = cyc;
        push_exp(n + 10, 4'hF, 4'h0, 4'hF);
        chk("release_sw", int'(o_sw), 0);
        step(12);
        chk("changed_after_release", int'(o_changed), 4'hF);

        // Drop all but channel 2, then clear flags
        i_sw = 4'b0100;
        n = cyc;
        push_exp(n + 10, 4'h0, 4'b1011, 4'b0100);
        step(12);
        clr_pulse();
        chk("changed_cleared_1", int'(o_changed), 0);

        // Glitch of 5 cycles on channel 0 is rejected
        i_sw = 4'b0101;
        step(5);
        i_sw = 4'b0100;
        step(15);
        chk("glitch_sw",      int'(o_sw),      4'b0100);
        chk("glitch_changed", int'(o_changed), 0);

        // Bounce on channel 1, then settle high
        i_sw = 4'b0110; step(1);
        i_sw = 4'b0100; step(1);
        i_sw = 4'b0110; step(1);
        i_sw = 4'b0100; step(1);
        i_sw = 4'b0110;
        n = cyc;
        push_exp(n + 10, 4'b0010, 4'h0, 4'b0110);
        step(12);
        chk("bounce_changed", int'(o_changed), 4'b0010);
        clr_pulse();
        chk("changed_cleared_2", int'(o_changed), 0);

        // Falling edge on channel 2 with a clear in the same cycle: set wins
        i_sw = 4'b0010;
        n = cyc;
        push_exp(n + 10, 4'h0, 4'b0100, 4'b0010);
        step(10);
        i_clr_changed = 1'b1;
        step(1);
        i_clr_changed = 1'b0;
        chk("set_wins_changed", int'(o_changed), 4'b0100);
        clr_pulse();
        chk("changed_cleared_3", int'(o_changed), 0);

        // Bypass: a one-cycle pattern passes straight through after sync
        i_debounce_en = 1'b0;
        step(2);
        i_sw = 4'b0101;
        n = cyc;
        push_exp(n + 3, 4'b0101, 4'b0010, 4'b0101);
        push_exp(n + 4, 4'b0010, 4'b0101, 4'b0010);
        step(1);
        i_sw = 4'b0010;
        step(6);
        chk("bypass_sw",      int'(o_sw),      4'b0010);
        chk("bypass_changed", int'(o_changed), 4'b0111);
        clr_pulse();

        // Re-enable together with a new level: full qualification required
        i_sw = 4'b1010;
        i_debounce_en = 1'b1;
        n = cyc;
        push_exp(n + 10, 4'b1000, 4'h0, 4'b1010);
        step(12);
        chk("reenable_sw", int'(o_sw), 4'b1010);

        // Async reset mid-count on channel 3 (counter at 5)
        i_sw = 4'b0010;
        step(7);
        reset_n = 1'b0;
        #1;
        chk("async_rst_sw",      int'(o_sw),      0);
        chk("async_rst_rise",    int'(o_rise),    0);
        chk("async_rst_fall",    int'(o_fall),    0);
        chk("async_rst_changed", int'(o_changed), 0);
        i_sw = 4'b1010;
        step(2);
        reset_n = 1'b1;
        n = cyc;
        push_exp(n + 10, 4'b1010, 4'h0, 4'b1010);
        step(12);
        chk("post_reset_changed", int'(o_changed), 4'b1010);

        chk("pending_events", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
